retire_ctrl: RTL and testbench

Retire-stage controller that sequences in-order commit out of the reorder buffer. Each cycle it examines the ROB's oldest `N` exit packets and drives `num_retiring` back to the ROB. It emits per-slot retire packets for the architectural map table and free list, and serialises store commits to memory through a req/ack handshake. It also owns the processor halt state.

---
 rtl/sys_defs.sv | 31 +++
 rtl/retire_prefix.sv | 41 ++++
 rtl/retire_ctrl.sv | 115 +++++++++++
 tb/tb_retire_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared retire-stage types: ROB exit/retire packets, FSM state and width constants.
package sys_defs;

  localparam int N               = 3;
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int ARCH_REG_W      = 5;
  localparam int PHYS_REG_W      = 6;

  typedef struct packed {
    logic                  complete;
    logic                  halt;
    logic                  is_store;
    logic [ARCH_REG_W-1:0] dest_reg_idx;
    logic [PHYS_REG_W-1:0] t;
    logic [PHYS_REG_W-1:0] t_old;
  } ROB_EXIT_PACKET;

  typedef struct packed {
    logic [ARCH_REG_W-1:0] dest_reg_idx;
    logic [PHYS_REG_W-1:0] t;
    logic [PHYS_REG_W-1:0] t_old;
  } RETIRE_PACKET;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    STORE_DONE = 2'd2,
    HALTED     = 2'd3
  } RETIRE_STATE;

endpackage

// File: rtl/retire_prefix.sv
// Finds the longest in-order retirable prefix of the ROB head window in RUN.
module retire_prefix
  import sys_defs::*;
(
  input  ROB_EXIT_PACKET             rob_outputs [N],
  input  logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input  RETIRE_STATE                state,
  output logic [NUM_SCALAR_BITS-1:0] k,
  output logic                       has_halt
);

  logic stop;
  logic unused_payload;

  always_comb begin
    k        = '0;
    has_halt = 1'b0;
    stop     = (state != RUN);
    // A store anywhere (including slot 0) ends the prefix; slot 0 stores go through the handshake.
    for (int i = 0; i < N; i++) begin
      if (!stop) begin
        if ((NUM_SCALAR_BITS'(i) >= rob_outputs_valid) || !rob_outputs[i].complete ||
            rob_outputs[i].is_store) begin
          stop = 1'b1;
        end else begin
          k = NUM_SCALAR_BITS'(i + 1);
          if (rob_outputs[i].halt) begin
            has_halt = 1'b1;
            stop     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    unused_payload = 1'b0;
    for (int i = 0; i < N; i++) unused_payload = unused_payload ^ (^rob_outputs[i]);
  end

endmodule

// File: rtl/retire_ctrl.sv
// Retire-stage controller: in-order commit, store serialisation, halt and retire count.
//
// state      | meaning
// RUN        | normal retirement of the complete head prefix
// STORE_WAIT | store at slot 0 requested to memory, waiting for ack
// STORE_DONE | store accepted during recovery, its retirement still pending
// HALTED     | halt retired; everything frozen until reset
module retire_ctrl
  import sys_defs::*;
#(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  ROB_EXIT_PACKET             rob_outputs [N],
  input  logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input  logic                       tail_restore_valid,
  output logic [NUM_SCALAR_BITS-1:0] num_retiring,
  output RETIRE_PACKET               retire_packets [N],
  output logic [N-1:0]               retire_valid,
  output logic                       store_req,
  input  logic                       store_ack,
  output logic                       halt,
  output logic [RETIRE_CNT_W-1:0]    retired_count
);

  RETIRE_STATE                state, state_nxt;
  logic [NUM_SCALAR_BITS-1:0] prefix_k;
  logic                       prefix_halt;
  logic                       store_at_head;
  logic                       halt_set;
  logic                       unused_rob;

  retire_prefix u_prefix (
    .rob_outputs       (rob_outputs),
    .rob_outputs_valid (rob_outputs_valid),
    .state             (state),
    .k                 (prefix_k),
    .has_halt          (prefix_halt)
  );

  assign store_at_head = (rob_outputs_valid != '0) && rob_outputs[0].complete &&
                         rob_outputs[0].is_store;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      halt          <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_nxt;
      retired_count <= retired_count + RETIRE_CNT_W'(num_retiring);
      if (halt_set) halt <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    num_retiring = '0;
    halt_set     = 1'b0;
    case (state)
      RUN: begin
        if (!tail_restore_valid) begin
          if (store_at_head) begin
            state_nxt = STORE_WAIT;
          end else begin
            num_retiring = prefix_k;
            if (prefix_halt) begin
              state_nxt = HALTED;
              halt_set  = 1'b1;
            end
          end
        end
      end
      STORE_WAIT: begin
        if (store_ack) begin
          if (tail_restore_valid) begin
            state_nxt = STORE_DONE;
          end else begin
            num_retiring = NUM_SCALAR_BITS'(1);
            state_nxt    = RUN;
          end
        end
      end
      STORE_DONE: begin
        if (!tail_restore_valid) begin
          num_retiring = NUM_SCALAR_BITS'(1);
          state_nxt    = RUN;
        end
      end
      HALTED: ;
    endcase
  end

  assign store_req = (state == STORE_WAIT);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      retire_valid[i]   = (NUM_SCALAR_BITS'(i) < num_retiring);
      retire_packets[i] = '0;
      if (retire_valid[i]) begin
        retire_packets[i].dest_reg_idx = rob_outputs[i].dest_reg_idx;
        retire_packets[i].t            = rob_outputs[i].t;
        retire_packets[i].t_old        = rob_outputs[i].t_old;
      end
    end
  end

  // Only slot-0 flags are decoded here; the prefix module sees the rest.
  always_comb begin
    unused_rob = 1'b0;
    for (int i = 0; i < N; i++) unused_rob = unused_rob ^ (^rob_outputs[i]);
  end

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed, table-driven bench for retire_ctrl with hand sequences for store, halt and reset.
module tb_retire_ctrl;
  import sys_defs::*;

  logic                       clock;
  logic                       reset;
  ROB_EXIT_PACKET             rob_outputs [N];
  logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid;
  logic                       tail_restore_valid;
  logic [NUM_SCALAR_BITS-1:0] num_retiring;
  RETIRE_PACKET               retire_packets [N];
  logic [N-1:0]               retire_valid;
  logic                       store_req;
  logic                       store_ack;
  logic                       halt;
  logic [31:0]                retired_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 0;

  retire_ctrl #(.RETIRE_CNT_W(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .rob_outputs        (rob_outputs),
    .rob_outputs_valid  (rob_outputs_valid),
    .tail_restore_valid (tail_restore_valid),
    .num_retiring       (num_retiring),
    .retire_packets     (retire_packets),
    .retire_valid       (retire_valid),
    .store_req          (store_req),
    .store_ack          (store_ack),
    .halt               (halt),
    .retired_count      (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] valid;
    logic [2:0] cmp;
    logic [2:0] st;
    logic [2:0] hl;
    logic       trv;
    logic [1:0] nr;
    logic [2:0] rv;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rob(input logic [1:0] v, input logic [2:0] c, input logic [2:0] s,
                         input logic [2:0] h);
    rob_outputs_valid = v;
    for (int i = 0; i < N; i++) begin
      rob_outputs[i].complete     = c[i];
      rob_outputs[i].is_store     = s[i];
      rob_outputs[i].halt         = h[i];
      rob_outputs[i].dest_reg_idx = 5'(i + 1);
      rob_outputs[i].t            = 6'(10 + i);
      rob_outputs[i].t_old        = 6'(20 + i);
    end
  endtask

  function automatic logic [31:0] exp_pkt(input int i, input logic v);
    logic [16:0] p;
    p = v ? {5'(i + 1), 6'(10 + i), 6'(20 + i)} : 17'd0;
    return {15'd0, p};
  endfunction

  task automatic chk_pkts(input string tag, input logic [2:0] rv);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_pkt%0d", tag, i),
          {15'd0, retire_packets[i].dest_reg_idx, retire_packets[i].t, retire_packets[i].t_old},
          exp_pkt(i, rv[i]));
  endtask

  initial begin
    //            valid cmp     st      hl      trv  nr    rv
    vecs[0]  = '{2'd3, 3'b011, 3'b000, 3'b000, 1'b0, 2'd2, 3'b011};
    vecs[1]  = '{2'd0, 3'b111, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000};
    vecs[2]  = '{2'd3, 3'b111, 3'b000, 3'b000, 1'b0, 2'd3, 3'b111};
    vecs[3]  = '{2'd2, 3'b111, 3'b000, 3'b000, 1'b0, 2'd2, 3'b011};
    vecs[4]  = '{2'd3, 3'b110, 3'b000, 3'b000, 1'b0, 2'd0, 3'b000};
    vecs[5]  = '{2'd3, 3'b111, 3'b010, 3'b000, 1'b0, 2'd1, 3'b001};
    vecs[6]  = '{2'd3, 3'b111, 3'b100, 3'b000, 1'b0, 2'd2, 3'b011};
    vecs[7]  = '{2'd3, 3'b111, 3'b000, 3'b000, 1'b1, 2'd0, 3'b000};
    vecs[8]  = '{2'd3, 3'b101, 3'b000, 3'b000, 1'b0, 2'd1, 3'b001};
    vecs[9]  = '{2'd1, 3'b111, 3'b000, 3'b000, 1'b0, 2'd1, 3'b001};
    vecs[10] = '{2'd3, 3'b110, 3'b001, 3'b000, 1'b0, 2'd0, 3'b000};

    reset = 1'b0;
    store_ack = 1'b0;
    tail_restore_valid = 1'b0;
    set_rob(2'd0, 3'b000, 3'b000, 3'b000);
    #2;
    chk("rst_store_req", {31'd0, store_req}, 0);
    chk("rst_halt", {31'd0, halt}, 0);
    chk("rst_count", retired_count, 0);
    chk("rst_nr", {30'd0, num_retiring}, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < 11; v++) begin
      @(negedge clock);
      set_rob(vecs[v].valid, vecs[v].cmp, vecs[v].st, vecs[v].hl);
      tail_restore_valid = vecs[v].trv;
      #1;
      chk($sformatf("vec%0d_nr", v), {30'd0, num_retiring}, {30'd0, vecs[v].nr});
      chk($sformatf("vec%0d_rv", v), {29'd0, retire_valid}, {29'd0, vecs[v].rv});
      chk_pkts($sformatf("vec%0d", v), vecs[v].rv);
      exp_count = exp_count + 32'(vecs[v].nr);
      @(posedge clock); #1;
      chk($sformatf("vec%0d_count", v), retired_count, exp_count);
      chk($sformatf("vec%0d_store_req", v), {31'd0, store_req}, 0);
      chk($sformatf("vec%0d_halt", v), {31'd0, halt}, 0);
    end

    // store at head: request, three idle cycles, then ack
    @(negedge clock);
    tail_restore_valid = 1'b0;
    set_rob(2'd3, 3'b111, 3'b001, 3'b000);
    #1;
    chk("st_entry_nr", {30'd0, num_retiring}, 0);
    chk("st_entry_req", {31'd0, store_req}, 0);
    @(posedge clock); #1;
    chk("st_req_up", {31'd0, store_req}, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      chk($sformatf("st_wait%0d_nr", c), {30'd0, num_retiring}, 0);
      chk($sformatf("st_wait%0d_req", c), {31'd0, store_req}, 1);
    end
    @(negedge clock);
    store_ack = 1'b1;
    #1;
    chk("st_ack_nr", {30'd0, num_retiring}, 1);
    chk("st_ack_rv", {29'd0, retire_valid}, 3'b001);
    chk_pkts("st_ack", 3'b001);
    exp_count = exp_count + 1;
    @(posedge clock); #1;
    chk("st_after_req", {31'd0, store_req}, 0);
    chk("st_after_count", retired_count, exp_count);
    @(negedge clock);
    store_ack = 1'b0;
    set_rob(2'd0, 3'b000, 3'b000, 3'b000);

    // ack arriving during branch recovery
    @(negedge clock);
    set_rob(2'd3, 3'b111, 3'b001, 3'b000);
    @(posedge clock); #1;
    chk("rec_req_up", {31'd0, store_req}, 1);
    @(negedge clock);
    store_ack = 1'b1;
    tail_restore_valid = 1'b1;
    #1;
    chk("rec_ack_nr", {30'd0, num_retiring}, 0);
    chk("rec_ack_rv", {29'd0, retire_valid}, 0);
    @(posedge clock); #1;
    chk("rec_done_req", {31'd0, store_req}, 0);
    chk("rec_done_count", retired_count, exp_count);
    @(negedge clock);
    store_ack = 1'b0;
    #1;
    chk("rec_hold_nr", {30'd0, num_retiring}, 0);
    @(negedge clock);
    tail_restore_valid = 1'b0;
    #1;
    chk("rec_free_nr", {30'd0, num_retiring}, 1);
    chk("rec_free_rv", {29'd0, retire_valid}, 3'b001);
    chk("rec_free_req", {31'd0, store_req}, 0);
    exp_count = exp_count + 1;
    @(posedge clock); #1;
    chk("rec_free_count", retired_count, exp_count);
    @(negedge clock);
    set_rob(2'd0, 3'b000, 3'b000, 3'b000);

    // halt suppressed by recovery, then taken
    @(negedge clock);
    set_rob(2'd3, 3'b111, 3'b000, 3'b010);
    tail_restore_valid = 1'b1;
    #1;
    chk("hrec_nr", {30'd0, num_retiring}, 0);
    @(posedge clock); #1;
    chk("hrec_halt", {31'd0, halt}, 0);
    @(negedge clock);
    tail_restore_valid = 1'b0;
    #1;
    chk("halt_nr", {30'd0, num_retiring}, 2);
    chk("halt_rv", {29'd0, retire_valid}, 3'b011);
    exp_count = exp_count + 2;
    @(posedge clock); #1;
    chk("halt_flag", {31'd0, halt}, 1);
    chk("halt_count", retired_count, exp_count);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      set_rob(2'd3, 3'b111, (c == 2) ? 3'b001 : 3'b000, 3'b000);
      #1;
      chk($sformatf("halted%0d_nr", c), {30'd0, num_retiring}, 0);
      chk($sformatf("halted%0d_rv", c), {29'd0, retire_valid}, 0);
      @(posedge clock); #1;
      chk($sformatf("halted%0d_count", c), retired_count, exp_count);
      chk($sformatf("halted%0d_req", c), {31'd0, store_req}, 0);
      chk($sformatf("halted%0d_halt", c), {31'd0, halt}, 1);
    end

    @(negedge clock);
    set_rob(2'd0, 3'b000, 3'b000, 3'b000);
    reset = 1'b0;
    #1;
    chk("hreset_halt", {31'd0, halt}, 0);
    chk("hreset_count", retired_count, 0);
    exp_count = 0;
    @(negedge clock);
    reset = 1'b1;

    // async reset in the middle of a store handshake
    @(negedge clock);
    set_rob(2'd3, 3'b111, 3'b001, 3'b000);
    @(posedge clock); #1;
    chk("ar_req_up", {31'd0, store_req}, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_req_drop", {31'd0, store_req}, 0);
    chk("ar_nr", {30'd0, num_retiring}, 0);
    set_rob(2'd0, 3'b000, 3'b000, 3'b000);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("ar_halt", {31'd0, halt}, 0);
    chk("ar_count", retired_count, 0);
    chk("ar_req_after", {31'd0, store_req}, 0);
    @(negedge clock);
    set_rob(2'd3, 3'b111, 3'b000, 3'b000);
    #1;
    chk("ar_run_nr", {30'd0, num_retiring}, 3);
    @(posedge clock); #1;
    chk("ar_run_count", retired_count, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
